ee354_gcd_driver: RTL

Hardware initiator for the ee354_GCD core's Start/Ack handshake. It accepts operand pairs from a host-side valid/ready port and drives Ain/Bin, Start and Ack into the core. It measures the core's compute time in enabled clocks and presents the GCD, cycle count and error flag on a held result port. It sits between a top-level operand source (switches, ROM or sequencer) and the GCD core, and obeys the same CEN single-step gating as the core.

---
 rtl/ee354_gcd_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ee354_gcd_driver.sv
// Start/Ack initiator for the ee354 GCD core: takes operand pairs from a host,
// times the core's computation in enabled clocks and holds the result for the host.
module ee354_gcd_driver #(
  parameter int W       = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CEN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  output logic             Start,
  output logic             Ack,
  output logic [W-1:0]     Ain,
  output logic [W-1:0]     Bin,
  input  logic             core_q_Sub,
  input  logic             core_q_Done,
  input  logic [W-1:0]     core_gcd,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [W-1:0]     res_gcd,
  output logic [W-1:0]     res_a,
  output logic [W-1:0]     res_b,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_err,
  output logic [7:0]       done_count
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_SUB, WAIT_DONE, ACK, REPORT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_op;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign zero_op = (req_a == '0) || (req_b == '0);

  // The awaited core flag wins over the limit when both land on the same edge.
  assign timeout = (cnt_q == TO_LAST) &&
                   (((state_q == WAIT_SUB)  && !core_q_Sub) ||
                    ((state_q == WAIT_DONE) && !core_q_Done));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req_valid) state_d = zero_op ? REPORT : START;
      START:     state_d = WAIT_SUB;
      WAIT_SUB:  if (core_q_Sub) state_d = WAIT_DONE;
                 else if (timeout) state_d = REPORT;
      WAIT_DONE: if (core_q_Done) state_d = ACK;
                 else if (timeout) state_d = REPORT;
      ACK:       state_d = REPORT;
      REPORT:    if (res_ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      Start      <= 1'b0;
      Ack        <= 1'b0;
      res_valid  <= 1'b0;
      Ain        <= '0;
      Bin        <= '0;
      res_gcd    <= '0;
      res_a      <= '0;
      res_b      <= '0;
      res_cycles <= '0;
      res_err    <= 1'b0;
      done_count <= '0;
      cnt_q      <= '0;
    end else if (CEN) begin
      // Handshake outputs are decoded from the next state so they are registered.
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      Start     <= (state_d == START);
      Ack       <= (state_d == ACK);
      res_valid <= (state_d == REPORT);

      unique case (state_q)
        IDLE: if (req_valid) begin
          Ain     <= req_a;
          Bin     <= req_b;
          res_a   <= req_a;
          res_b   <= req_b;
          res_err <= zero_op;
          if (zero_op) begin
            res_gcd    <= '0;
            res_cycles <= '0;
          end
        end
        START:    cnt_q <= '0;
        WAIT_SUB: cnt_q <= core_q_Sub ? '0 : sat_inc(cnt_q);
        WAIT_DONE: begin
          if (core_q_Done) begin
            res_gcd    <= core_gcd;
            res_cycles <= sat_inc(cnt_q);
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        REPORT: if (res_ack) done_count <= done_count + 8'd1;
        default: ;
      endcase

      if (timeout) begin
        res_err    <= 1'b1;
        res_gcd    <= '0;
        res_cycles <= TO_VAL;
      end
    end
  end

endmodule
